log2_approx_pipe: RTL and testbench

Pipelined base-2 logarithm approximator for the softmax datapath; it is the inverse-direction companion of the stage-3 pow2 approximator. It takes a positive unsigned Q6.10 value, typically the exponential sum, and produces a signed Q6.10 log2 result for the log-domain normalisation subtract. The algorithm is Mitchell's approximation with an optional quadratic correction term. It has three register stages, a valid flag that travels with the data, a global enable stall, and a bypass copy of the input aligned to the result.

---
 rtl/softmax_fxp_pkg.sv | 14 +
 rtl/log2_approx_pipe_lod16.sv | 25 ++
 rtl/log2_approx_pipe.sv | 129 ++++++++++++
 tb/tb_log2_approx_pipe.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/softmax_fxp_pkg.sv
// Shared fixed-point constants for the softmax datapath (Q6.10 format).
package softmax_fxp_pkg;

  localparam int unsigned FXP_W    = 16;
  localparam int unsigned FXP_FRAC = 10;

  // log2 result used for a zero operand (-32.0 in Q6.10)
  localparam logic [15:0] LOG2_NEG_SAT = 16'h8000;

  // Quadratic correction: corr = (f*(1-f)*LOG2_CORR_NUM) >> LOG2_CORR_SHIFT
  localparam int unsigned LOG2_CORR_NUM   = 11;
  localparam int unsigned LOG2_CORR_SHIFT = 15;

endpackage

// File: rtl/log2_approx_pipe_lod16.sv
// lod16: combinational 16-bit leading-one detector.
// pos is the index of the most significant set bit; zero flags an all-zero
// input (pos reads 0 in that case).
module lod16
  import softmax_fxp_pkg::*;
(
  input  logic [FXP_W-1:0] data,
  output logic [3:0]       pos,
  output logic             zero
);

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    pos  = 4'd0;
    zero = (data == 16'd0);
    for (int i = 0; i < 16; i++) begin
      if (data[i]) begin
        pos = 4'(i);
      end else begin
        pos = pos;
      end
    end
  end

endmodule

// File: rtl/log2_approx_pipe.sv
// log2_approx_pipe: three-stage Mitchell log2 approximator, unsigned Q6.10 in,
// signed Q6.10 out. Stage 1 captures the operand and its leading-one position,
// stage 2 normalises to integer part + 10-bit fraction, stage 3 adds the
// optional quadratic correction and forms the result.
// Build option: define LOG2_CORR_EN to add the quadratic correction term;
// otherwise the result is pure Mitchell and no multiplier is built.
module log2_approx_pipe
  import softmax_fxp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_in,
  input  logic [FXP_W-1:0] in_x,
  output logic             valid_out,
  output logic [FXP_W-1:0] log_in_x,
  output logic [FXP_W-1:0] in_x_bypass,
  output logic             zero_out
);

  // Leading-one detector outputs for the raw operand
  logic [3:0]       w_pos;
  logic             w_zero;

  // Stage 1 registers
  logic             r1_valid;
  logic             r1_zero;
  logic [3:0]       r1_p;
  logic [FXP_W-1:0] r1_x;

  // Stage 2 combinational and registers
  logic [14:0]      w_norm;
  logic [9:0]       w_f;
  logic [4:0]       w_ip;
  logic             r2_valid;
  logic             r2_zero;
  logic [9:0]       r2_f;
  logic [4:0]       r2_ip;
  logic [FXP_W-1:0] r2_x;

  // Stage 3 combinational and registers
  logic [6:0]       w_corr;
  logic [FXP_W-1:0] w_sum;
  logic [FXP_W-1:0] w_result;
  logic             r3_valid;
  logic             r3_zero;
  logic [FXP_W-1:0] r3_log;
  logic [FXP_W-1:0] r3_x;

  lod16 u_lod16 (
    .data (in_x),
    .pos  (w_pos),
    .zero (w_zero)
  );

  // Normalise: shift the leading one to bit 15 (dropped), keep the next 10 bits
  // as fraction; integer part is the leading-one position minus the Q6.10 point.
  always_comb begin
    w_norm = 15'(r1_x << (4'd15 - r1_p));
    w_f    = 10'(w_norm >> 5);
    w_ip   = {1'b0, r1_p} - 5'd10;
  end

`ifdef LOG2_CORR_EN
  logic [19:0] w_fmul;
  logic [23:0] w_scaled;

  // Quadratic correction f*(1-f)*11/32768, at most 88 LSBs at f = 0.5
  always_comb begin
    w_fmul   = 20'(r2_f) * (20'd1024 - 20'(r2_f));
    w_scaled = 24'(w_fmul) * 24'(LOG2_CORR_NUM);
    w_corr   = 7'(w_scaled >> LOG2_CORR_SHIFT);
  end
`else
  // Pure Mitchell: no correction term
  always_comb begin
    w_corr = 7'd0;
  end
`endif

  // Final sum: sign-extended integer part, fraction and correction; zero saturates
  always_comb begin
    w_sum = {r2_ip[4], r2_ip, 10'd0} + {6'd0, r2_f} + {9'd0, w_corr};
    if (r2_zero) begin
      w_result = LOG2_NEG_SAT;
    end else begin
      w_result = w_sum;
    end
  end

  // Pipeline registers: async clear, hold everything (valid included) when en = 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_valid <= 1'b0;
      r1_zero  <= 1'b0;
      r1_p     <= 4'd0;
      r1_x     <= 16'd0;
      r2_valid <= 1'b0;
      r2_zero  <= 1'b0;
      r2_f     <= 10'd0;
      r2_ip    <= 5'd0;
      r2_x     <= 16'd0;
      r3_valid <= 1'b0;
      r3_zero  <= 1'b0;
      r3_log   <= 16'd0;
      r3_x     <= 16'd0;
    end else if (en) begin
      r1_valid <= valid_in;
      r1_zero  <= w_zero;
      r1_p     <= w_pos;
      r1_x     <= in_x;
      r2_valid <= r1_valid;
      r2_zero  <= r1_zero;
      r2_f     <= w_f;
      r2_ip    <= w_ip;
      r2_x     <= r1_x;
      r3_valid <= r2_valid;
      r3_zero  <= r2_zero;
      r3_log   <= w_result;
      r3_x     <= r2_x;
    end
  end

  assign valid_out   = r3_valid;
  assign log_in_x    = r3_log;
  assign in_x_bypass = r3_x;
  assign zero_out    = r3_zero;

endmodule

// File: tb/tb_log2_approx_pipe.sv
// Directed self-checking bench for log2_approx_pipe. Inputs are driven on the
// falling edge, outputs sampled on the falling edge after the rising edge.
module tb_log2_approx_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic [15:0] in_x;
  logic        valid_out;
  logic [15:0] log_in_x;
  logic [15:0] in_x_bypass;
  logic        zero_out;

  int errors = 0;
  int checks = 0;

  log2_approx_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .valid_in    (valid_in),
    .in_x        (in_x),
    .valid_out   (valid_out),
    .log_in_x    (log_in_x),
    .in_x_bypass (in_x_bypass),
    .zero_out    (zero_out)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One isolated operand: valid output must appear exactly on the third edge.
  task automatic run_one(input string tag, input logic [15:0] x,
                         input logic [15:0] exp_log, input logic exp_zero);
    @(negedge clk); valid_in = 1'b1; in_x = x; en = 1'b1;
    @(negedge clk); valid_in = 1'b0; in_x = 16'h0000;
    @(negedge clk); chk1({tag, "_early"}, valid_out, 1'b0);
    @(negedge clk);
    chk1({tag, "_valid"}, valid_out, 1'b1);
    chk16({tag, "_log"}, log_in_x, exp_log);
    chk16({tag, "_bypass"}, in_x_bypass, x);
    chk1({tag, "_zero"}, zero_out, exp_zero);
  endtask

  logic        exp_v [0:7];
  logic [15:0] exp_l [0:7];
  logic [15:0] alt_x [0:7];

  initial begin
    rst = 1'b0; en = 1'b0; valid_in = 1'b0; in_x = 16'h0000;
    #2;
    chk1("rst_valid", valid_out, 1'b0);
    chk16("rst_log", log_in_x, 16'h0000);
    chk16("rst_bypass", in_x_bypass, 16'h0000);
    chk1("rst_zero", zero_out, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1; en = 1'b1;

    // Basic values
    run_one("one",  16'h0400, 16'h0000, 1'b0);
    run_one("two",  16'h0800, 16'h0400, 1'b0);
    run_one("lsb",  16'h0001, 16'hD800, 1'b0);
`ifdef LOG2_CORR_EN
    run_one("p1_5", 16'h0600, 16'h0258, 1'b0);
`else
    run_one("p1_5", 16'h0600, 16'h0200, 1'b0);
`endif
    run_one("max",  16'hFFFF, 16'h17FF, 1'b0);
    run_one("zero", 16'h0000, 16'h8000, 1'b1);
    run_one("after_zero", 16'h2000, 16'h0C00, 1'b0);

    // Stream with a 2-cycle stall after the second operand
    // per-edge expected outputs after edges E1..E8
    exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_v[2] = 1'b0; exp_v[3] = 1'b0;
    exp_v[4] = 1'b1; exp_v[5] = 1'b1; exp_v[6] = 1'b1; exp_v[7] = 1'b0;
    exp_l[4] = 16'h0000; exp_l[5] = 16'h0400; exp_l[6] = 16'h0800;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      if (e > 0) chk1($sformatf("stall_valid_e%0d", e), valid_out, exp_v[e-1]);
      if (e > 0 && exp_v[e-1]) chk16($sformatf("stall_log_e%0d", e), log_in_x, exp_l[e-1]);
      case (e)
        0: begin en = 1'b1; valid_in = 1'b1; in_x = 16'h0400; end
        1: begin en = 1'b1; valid_in = 1'b1; in_x = 16'h0800; end
        2: begin en = 1'b0; valid_in = 1'b1; in_x = 16'hAAAA; end
        3: begin en = 1'b0; valid_in = 1'b0; in_x = 16'h5555; end
        4: begin en = 1'b1; valid_in = 1'b1; in_x = 16'h1000; end
        default: begin en = 1'b1; valid_in = 1'b0; in_x = 16'h0000; end
      endcase
    end
    @(negedge clk);
    chk1("stall_valid_e8", valid_out, exp_v[7]);

    // Asynchronous reset with three operands in flight
    valid_in = 1'b1; in_x = 16'h0400;
    @(negedge clk); in_x = 16'h0800;
    @(negedge clk); in_x = 16'h1000;
    @(negedge clk); valid_in = 1'b0; in_x = 16'h0000;
    chk1("inflight_valid", valid_out, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("arst_valid", valid_out, 1'b0);
    chk16("arst_log", log_in_x, 16'h0000);
    chk16("arst_bypass", in_x_bypass, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1($sformatf("post_rst_valid_%0d", k), valid_out, 1'b0);
    end
    run_one("post_rst", 16'h0800, 16'h0400, 1'b0);

    // Alternating valid pattern
    for (int k = 0; k < 8; k++) alt_x[k] = 16'h0100 * 16'(k + 1);
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        chk1($sformatf("alt_valid_%0d", j - 3), valid_out, ((j - 3) % 2) == 0);
        chk16($sformatf("alt_bypass_%0d", j - 3), in_x_bypass, alt_x[j-3]);
      end
      if (j < 8) begin
        valid_in = ((j % 2) == 0); in_x = alt_x[j];
      end else begin
        valid_in = 1'b0; in_x = 16'h0000;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
